block_fetch: RTL and testbench
==============================

# block_fetch

Sequential, parametrised tile extractor: on `start` it reads a J×K tile of a row-major matrix from a synchronous-read memory port, one element per cycle, into a flat block register. Out-of-range elements are zero-padded without issuing a read, and an optional transpose mode stores the tile column-major. It feeds the systolic/MAC datapath with operand tiles. It supersedes the combinational whole-buffer tile getter with an explicit row bound, a memory handshake and a done/valid protocol.

## Interface

Parameters:

- DATA_W, 16, element width in bits
- J, 2, tile rows
- K, 2, tile columns
- DIM_W, 10, width of row/column coordinates and dimensions
- ADDR_W, 10, memory word-address width

Ports:

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only in IDLE
- start_row  in  DIM_W  tile origin row
- start_col  in  DIM_W  tile origin column
- num_rows  in  DIM_W  matrix row count
- num_cols  in  DIM_W  matrix column count (row stride)
- transpose  in  1  0: slot i*K+j; 1: slot j*J+i
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read word address
- mem_rd_data  in  DATA_W  read data, valid exactly one cycle after mem_rd_en
- busy  out  1  high in FETCH and DRAIN
- done  out  1  one-cycle pulse when the tile is complete
- block_valid  out  1  tile contents valid
- block  out  J*K*DATA_W  tile; slot s occupies bits [s*DATA_W +: DATA_W]

## Operation

- States:
  - IDLE -> FETCH on start (all request inputs captured into registers).
  - FETCH -> DRAIN after element index J*K-1 is issued.
  - DRAIN -> IDLE. Capture of the last element completes, and done is asserted in the following cycle.
- Element counter n = 0..J*K-1, with i = n / K and j = n % K, implemented as nested i/j counters with no divider.
- Element (i,j) is in range iff start_row+i < num_rows and start_col+j < num_cols. Comparisons are done at DIM_W+1 bits so sums cannot wrap.
- In range:
  - mem_rd_en=1 and mem_addr = (start_row+i)*num_cols + start_col + j, truncated to ADDR_W. The caller guarantees it fits.
  - The returned data is written into the slot on the following clock edge.
- Out of range:
  - mem_rd_en=0; the slot is written with 0 in the same pipeline position. Every slot is written on every operation.
- A one-stage capture register holds {pending, slot index, is_read} for each issued element.
- transpose is latched at start and selects the slot mapping.
- block_valid:
  - Clears on start acceptance.
  - Sets together with done.
  - Holds until the next accepted start.
- block contents are unspecified while block_valid=0.
- start while busy: ignored, with no effect on the running operation.
- start in the cycle done is high: accepted, because the FSM is already in IDLE.
- num_rows=0 or num_cols=0: the tile is all zeros and no reads are issued; timing is unchanged.

## Timing

- Reset values: state IDLE, mem_rd_en 0, mem_addr 0, busy 0, done 0, block_valid 0, block all zeros, counters and capture register cleared.
- Reset mid-operation: same values on the next edge; the in-flight read data is discarded.
- Start sampled at edge ending cycle 0:
  - FETCH covers cycles 1..J*K, with element n issued in cycle n+1.
  - DRAIN is cycle J*K+1.
  - done and block_valid go high in cycle J*K+2.
- Fixed latency J*K+2 cycles, independent of padding. Throughput is one tile per J*K+2 cycles; with back-to-back start, a new FETCH begins the cycle after done.
- mem_addr and mem_rd_en are registered outputs.

## Structure

- Shared package neurocore_pkg: default DATA_W, J, K, DIM_W, ADDR_W constants; state enum (IDLE, FETCH, DRAIN); slot-index function for transpose mapping.
- One natural sub-module: block_addr_gen. It contains the i/j counters, bound comparison, address multiply-add and last-element flag, and drives {issue, in_range, addr, slot}.
- The top level holds the FSM, capture register and block register.

## Test plan

- 3×4 matrix with mem[a]=a+1, J=K=2, tile (0,1), transpose=0:
  - block = {2,3,6,7}.
  - 4 reads at addresses 1,2,5,6.
  - done in cycle 6.
- Same matrix, tile (2,3):
  - block = {12,0,0,0}.
  - Exactly one read, at address 11.
  - done still in cycle 6.
- Tile (0,1), transpose=1: block = {2,6,3,7}.
- start pulses in cycles 2 and 4 during an operation:
  - Ignored; a single done pulse.
  - A start held through the done cycle begins a second operation whose done arrives 6 cycles later.
- rst asserted in cycle 3 of an operation:
  - Next cycle busy=0, mem_rd_en=0, block_valid=0, block=0.
  - No done pulse.
  - A subsequent start completes normally.
- num_cols=0: block all zero, no mem_rd_en, done in cycle 6.

Source files
------------

// File: rtl/neurocore_pkg.sv
// neurocore_pkg: shared default sizes, fetch FSM state type and tile slot mapping
package neurocore_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_J = 2;
  localparam int DEF_K = 2;
  localparam int DEF_DIM_W = 10;
  localparam int DEF_ADDR_W = 10;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  function automatic int slot_idx(input int i, input int j, input int rows, input int cols, input logic tr);
    return tr ? j * rows + i : i * cols + j;
  endfunction
endpackage

// File: rtl/block_fetch_if.sv
// block_fetch_if: request (start/origin/dims/transpose), memory read port (rd_en/addr/rd_data) and status (busy/done/block_valid/block)
interface block_fetch_if import neurocore_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int J = DEF_J,
  parameter int K = DEF_K,
  parameter int DIM_W = DEF_DIM_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic start;
  logic [DIM_W-1:0] start_row;
  logic [DIM_W-1:0] start_col;
  logic [DIM_W-1:0] num_rows;
  logic [DIM_W-1:0] num_cols;
  logic transpose;
  logic mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic busy;
  logic done;
  logic block_valid;
  logic [J*K*DATA_W-1:0] block;
  modport master (
    output start, start_row, start_col, num_rows, num_cols, transpose, mem_rd_data,
    input mem_rd_en, mem_addr, busy, done, block_valid, block
  );
  modport slave (
    input start, start_row, start_col, num_rows, num_cols, transpose, mem_rd_data,
    output mem_rd_en, mem_addr, busy, done, block_valid, block
  );
endinterface

// File: rtl/block_addr_gen.sv
// block_addr_gen: i/j element counters advanced by step; drives issue, in_range, addr, slot and last-element flag
module block_addr_gen import neurocore_pkg::*; #(
  parameter int J = DEF_J,
  parameter int K = DEF_K,
  parameter int DIM_W = DEF_DIM_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SW = (J * K > 1) ? $clog2(J * K) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic tr,
  input  logic [DIM_W-1:0] row0,
  input  logic [DIM_W-1:0] col0,
  input  logic [DIM_W-1:0] nrows,
  input  logic [DIM_W-1:0] ncols,
  output logic issue,
  output logic in_range,
  output logic last,
  output logic [ADDR_W-1:0] addr,
  output logic [SW-1:0] slot
);
  localparam int IW = (J > 1) ? $clog2(J) : 1;
  localparam int JW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * DIM_W + 2;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [DIM_W:0] r, c;
  assign r = {1'b0, row0} + (DIM_W+1)'(i);
  assign c = {1'b0, col0} + (DIM_W+1)'(j);
  assign in_range = r < {1'b0, nrows} && c < {1'b0, ncols};
  assign addr = ADDR_W'(PW'(r) * PW'(ncols) + PW'(c));
  assign last = i == IW'(J - 1) && j == JW'(K - 1);
  assign slot = SW'(slot_idx(int'(i), int'(j), J, K, tr));
  assign issue = step;
  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (step) begin
      j <= j == JW'(K - 1) ? '0 : j + 1'b1;
      if (j == JW'(K - 1)) i <= i == IW'(J - 1) ? '0 : i + 1'b1;
    end
  end
endmodule

// File: rtl/block_fetch.sv
// block_fetch: reads a JxK tile (zero-padded, optional transpose) from a sync-read memory; ports clk, rst, bus (block_fetch_if.slave)
module block_fetch import neurocore_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int J = DEF_J,
  parameter int K = DEF_K,
  parameter int DIM_W = DEF_DIM_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic rst,
  block_fetch_if.slave bus
);
  localparam int SW = (J * K > 1) ? $clog2(J * K) : 1;
  state_t state;
  logic [DIM_W-1:0] row0_q, col0_q, nrows_q, ncols_q;
  logic tr_q, idle, step, issue, in_range, last, iss_v, last_q, cap_v, cap_rd;
  logic [ADDR_W-1:0] addr;
  logic [SW-1:0] slot, iss_slot, cap_slot;
  assign idle = state == IDLE;
  assign step = idle ? bus.start : state == FETCH && !last_q;
  assign bus.busy = !idle;
  block_addr_gen #(.J(J), .K(K), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .SW(SW)) u_gen (
    .clk(clk),
    .rst(rst),
    .step(step),
    .tr(idle ? bus.transpose : tr_q),
    .row0(idle ? bus.start_row : row0_q),
    .col0(idle ? bus.start_col : col0_q),
    .nrows(idle ? bus.num_rows : nrows_q),
    .ncols(idle ? bus.num_cols : ncols_q),
    .issue(issue),
    .in_range(in_range),
    .last(last),
    .addr(addr),
    .slot(slot)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row0_q <= '0;
      col0_q <= '0;
      nrows_q <= '0;
      ncols_q <= '0;
      tr_q <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr <= '0;
      iss_v <= 1'b0;
      iss_slot <= '0;
      last_q <= 1'b0;
      cap_v <= 1'b0;
      cap_rd <= 1'b0;
      cap_slot <= '0;
      bus.done <= 1'b0;
      bus.block_valid <= 1'b0;
      bus.block <= '0;
    end else begin
      bus.mem_rd_en <= issue && in_range;
      bus.mem_addr <= issue && in_range ? addr : bus.mem_addr;
      iss_v <= issue;
      iss_slot <= slot;
      last_q <= issue && last;
      cap_v <= iss_v;
      cap_rd <= bus.mem_rd_en;
      cap_slot <= iss_slot;
      if (cap_v) bus.block[int'(cap_slot)*DATA_W +: DATA_W] <= cap_rd ? bus.mem_rd_data : '0;
      bus.done <= state == DRAIN;
      if (idle && bus.start) begin
        state <= FETCH;
        row0_q <= bus.start_row;
        col0_q <= bus.start_col;
        nrows_q <= bus.num_rows;
        ncols_q <= bus.num_cols;
        tr_q <= bus.transpose;
        bus.block_valid <= 1'b0;
      end else if (state == FETCH && last_q) begin
        state <= DRAIN;
      end else if (state == DRAIN) begin
        state <= IDLE;
        bus.block_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_block_fetch.sv
// tb_block_fetch: directed vectors against a 3x4 matrix with mem[a]=a+1
module tb_block_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int done_cyc, n_done, n_rd, d1, d2;
  logic [63:0] rd_log;
  logic [15:0] mem [16];
  block_fetch_if bus ();
  block_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.mem_rd_data <= mem[bus.mem_addr[3:0]];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input logic [9:0] r, input logic [9:0] c, input logic [9:0] nr, input logic [9:0] nc, input logic t);
    bus.start_row = r;
    bus.start_col = c;
    bus.num_rows = nr;
    bus.num_cols = nc;
    bus.transpose = t;
  endtask
  task automatic run_op(input logic [9:0] r, input logic [9:0] c, input logic [9:0] nr, input logic [9:0] nc, input logic t);
    set_req(r, c, nr, nc, t);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_cyc = 0;
    n_done = 0;
    n_rd = 0;
    rd_log = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        n_rd++;
        rd_log = {rd_log[47:0], 6'd0, bus.mem_addr};
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
    end
  endtask
  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 16'(a + 1);
    bus.start = 1'b0;
    bus.mem_rd_data = '0;
    set_req(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_valid", 64'(bus.block_valid), 0);
    check("rst_rden", 64'(bus.mem_rd_en), 0);
    check("rst_addr", 64'(bus.mem_addr), 0);
    check("rst_block", bus.block, 0);
    rst = 1'b0;
    run_op(0, 1, 3, 4, 0);
    check("t1_block", bus.block, 64'h0007_0006_0003_0002);
    check("t1_nrd", 64'(n_rd), 4);
    check("t1_addrs", rd_log, 64'h0001_0002_0005_0006);
    check("t1_done_cyc", 64'(done_cyc), 6);
    check("t1_ndone", 64'(n_done), 1);
    check("t1_valid", 64'(bus.block_valid), 1);
    run_op(2, 3, 3, 4, 0);
    check("t2_block", bus.block, 64'h0000_0000_0000_000C);
    check("t2_nrd", 64'(n_rd), 1);
    check("t2_addrs", rd_log, 64'h0000_0000_0000_000B);
    check("t2_done_cyc", 64'(done_cyc), 6);
    run_op(0, 1, 3, 4, 1);
    check("t3_block", bus.block, 64'h0007_0003_0006_0002);
    check("t3_done_cyc", 64'(done_cyc), 6);
    set_req(0, 1, 3, 4, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    d1 = 0;
    d2 = 0;
    n_done = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (d1 == 0) d1 = cyc;
        else if (d2 == 0) d2 = cyc;
      end
      bus.start = (cyc == 2 || cyc == 4 || cyc == 5 || cyc == 6);
    end
    bus.start = 1'b0;
    check("t4_ndone", 64'(n_done), 2);
    check("t4_done1", 64'(d1), 6);
    check("t4_done2", 64'(d2), 12);
    check("t4_block", bus.block, 64'h0007_0006_0003_0002);
    set_req(0, 1, 3, 4, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n_done = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (cyc == 3) rst = 1'b1;
      if (cyc == 4) begin
        check("t5_busy", 64'(bus.busy), 0);
        check("t5_rden", 64'(bus.mem_rd_en), 0);
        check("t5_valid", 64'(bus.block_valid), 0);
        check("t5_block", bus.block, 0);
        rst = 1'b0;
      end
    end
    check("t5_ndone", 64'(n_done), 0);
    run_op(1, 0, 3, 4, 0);
    check("t5_after_block", bus.block, 64'h000A_0009_0006_0005);
    check("t5_after_done", 64'(done_cyc), 6);
    run_op(0, 1, 3, 0, 0);
    check("t6_block", bus.block, 0);
    check("t6_nrd", 64'(n_rd), 0);
    check("t6_done_cyc", 64'(done_cyc), 6);
    check("t6_valid", 64'(bus.block_valid), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
